pos_edge_detector: RTL and testbench



---
 rtl/pos_edge_detector.sv | 98 +++++++++
 tb/tb_pos_edge_detector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pos_edge_detector.sv
// pos_edge_detector
//
// Rising-edge detector for level inputs in the clk domain. Each lane passes
// through an optional synchronizer chain, a history flop and a registered
// output flop. dout pulses high for exactly one clk period per 0->1 transition
// of the synchronized input. A saturating counter tallies the cycles in which
// any lane pulsed.
//
// Parameters
//   WIDTH        number of independent detection lanes (>= 1)
//   SYNC_STAGES  synchronizer depth ahead of detection, 0..3
//                (0: din is already synchronous to clk)
//   CNT_WIDTH    width of edge_cnt (>= 1)
//
// Ports
//   clk       in   rising-edge clock
//   nrst      in   asynchronous reset, active HIGH despite its name
//   din       in   [WIDTH]     level inputs, one per lane
//   cnt_clr   in   synchronous clear of edge_cnt, wins over increment
//   dout      out  [WIDTH]     registered one-cycle rising-edge pulse per lane
//   edge_cnt  out  [CNT_WIDTH] saturating count of cycles with any dout bit set

module pos_edge_detector #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     dout,
    output logic [CNT_WIDTH-1:0] edge_cnt
);

    logic [WIDTH-1:0] din_s;
    logic [WIDTH-1:0] din_q;
    logic             primed;
    logic             any_pulse;
    logic             cnt_full;

    // Synchronizer chain; stage 0 captures din directly.
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign din_s = din;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

            always_ff @(posedge clk or posedge nrst) begin
                if (nrst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= din;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign din_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // The first edge after reset release only loads history, so a lane that is
    // already high when reset drops does not report a false edge.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            din_q <= '0;
            dout  <= '0;
        end else begin
            din_q <= din_s;
            dout  <= din_s & ~din_q & {WIDTH{primed}};
        end
    end

    // Counts pulse cycles, not lanes: simultaneous lane pulses add one.
    assign any_pulse = |dout;
    assign cnt_full  = &edge_cnt;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            edge_cnt <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
        end else if (any_pulse && !cnt_full) begin
            edge_cnt <= edge_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pos_edge_detector.sv
// Bench for pos_edge_detector: two instances (no synchronizer with a 2-bit
// counter, and a 2-stage synchronizer with an 8-bit counter) share stimulus and
// are compared each cycle against a history-based reference model.

module tb_pos_edge_detector;

    logic       clk = 1'b1;
    logic       nrst;
    logic [3:0] din;
    logic       cnt_clr;

    logic [3:0] dout_a;
    logic [1:0] cnt_a;
    logic [3:0] dout_b;
    logic [7:0] cnt_b;

    always #5 clk = ~clk;

    pos_edge_detector #(.WIDTH(4), .SYNC_STAGES(0), .CNT_WIDTH(2)) u_a (
        .clk      (clk),
        .nrst     (nrst),
        .din      (din),
        .cnt_clr  (cnt_clr),
        .dout     (dout_a),
        .edge_cnt (cnt_a)
    );

    pos_edge_detector #(.WIDTH(4), .SYNC_STAGES(2), .CNT_WIDTH(8)) u_b (
        .clk      (clk),
        .nrst     (nrst),
        .din      (din),
        .cnt_clr  (cnt_clr),
        .dout     (dout_b),
        .edge_cnt (cnt_b)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: every din sample taken since the last reset release.
    logic [3:0] hist[$];
    logic [3:0] m_dout_a, m_dout_b;
    int         m_cnt_a, m_cnt_b;

    // Synchronized value seen by detection at post-reset edge j.
    function automatic logic [3:0] ds(input int stages, input int j);
        if (j - stages < 0) return 4'h0;
        return hist[j - stages];
    endfunction

    // Pulse produced by post-reset edge j: a rise between consecutive
    // synchronized samples, never on edge 0 (priming).
    function automatic logic [3:0] rise_at(input int stages, input int j);
        if (j < 1) return 4'h0;
        return ds(stages, j) & ~ds(stages, j - 1);
    endfunction

    task automatic model_reset();
        hist.delete();
        m_dout_a = 4'h0;
        m_dout_b = 4'h0;
        m_cnt_a  = 0;
        m_cnt_b  = 0;
    endtask

    task automatic model_edge();
        int j;
        if (nrst) return;
        hist.push_back(din);
        j = hist.size() - 1;
        if (cnt_clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            if (m_dout_a != 0 && m_cnt_a < 3)   m_cnt_a++;
            if (m_dout_b != 0 && m_cnt_b < 255) m_cnt_b++;
        end
        m_dout_a = rise_at(0, j);
        m_dout_b = rise_at(2, j);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dout_a", 32'(dout_a), 32'(m_dout_a));
        chk("cnt_a",  32'(cnt_a),  32'(m_cnt_a));
        chk("dout_b", 32'(dout_b), 32'(m_dout_b));
        chk("cnt_b",  32'(cnt_b),  32'(m_cnt_b));
    endtask

    task automatic step(input logic [3:0] d, input logic c);
        din     = d;
        cnt_clr = c;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    // Asynchronous reset pulse starting 2 units after the current point.
    task automatic async_reset_mid_cycle();
        #2 nrst = 1'b1;
        model_reset();
        #1 check_all();
    endtask

    task automatic release_at_negedge();
        @(negedge clk);
        nrst = 1'b0;
    endtask

    initial begin
        nrst    = 1'b1;
        din     = 4'h0;
        cnt_clr = 1'b0;
        model_reset();

        // Reset held for 15 units while din toggles.
        #1  check_all();
        #3  din = 4'hF;
        #2  check_all();
        #5  din = 4'h0;
        #2  check_all();
        #2  nrst = 1'b0;

        // Single edge held high for 5 cycles.
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);
        step(4'h1, 1'b0);
        chk("single_pulse", 32'(dout_a[0]), 32'd1);
        for (int i = 0; i < 5; i++) step(4'h1, 1'b0);
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);

        // Priming: din high across reset release.
        step(4'h1, 1'b0);
        async_reset_mid_cycle();
        release_at_negedge();
        for (int i = 0; i < 3; i++) step(4'h1, 1'b0);
        chk("prime_no_pulse", 32'(dout_a), 32'd0);
        step(4'h0, 1'b0);
        step(4'h1, 1'b0);
        step(4'h1, 1'b0);
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);

        // Alternating input, 8 cycles starting at 0.
        for (int i = 0; i < 8; i++) step((i % 2) ? 4'h1 : 4'h0, 1'b0);
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);

        // Sub-cycle glitch between edges is not seen.
        din = 4'hF;
        #3 din = 4'h0;
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);

        // Mid-pulse reset, held across one edge, then normal operation.
        step(4'h0, 1'b0);
        step(4'h3, 1'b0);
        chk("pulse_before_reset", 32'(dout_a), 32'h3);
        async_reset_mid_cycle();
        chk("reset_truncates", 32'(dout_a), 32'd0);
        step(4'hF, 1'b0);
        release_at_negedge();
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);
        step(4'h2, 1'b0);
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);

        // Counter saturation, clear during a pulse, multi-lane increment.
        for (int i = 0; i < 5; i++) begin
            step(4'h0, 1'b0);
            step(4'h1, 1'b0);
        end
        step(4'h0, 1'b0);
        chk("cnt_saturated", 32'(cnt_a), 32'd3);
        step(4'h1, 1'b0);
        step(4'h1, 1'b1);
        chk("cnt_clr_over_pulse", 32'(cnt_a), 32'd0);
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);
        step(4'hF, 1'b0);
        step(4'hF, 1'b0);
        chk("multilane_plus_one", 32'(cnt_a), 32'd1);
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);

        // Randomized traffic with occasional clears and asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                async_reset_mid_cycle();
                step(4'($urandom), 1'b0);
                release_at_negedge();
            end
            step(4'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
